pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//  Program-counter generator and instruction-ROM request sequencer; sits directly upstream of IF_stage.
//  Holds the architectural fetch PC and drives it to IF_stage (pc_if) and to the ROM request port.
//  Advances sequentially on accepted fetches and redirects on branch.
//  Freezes under IF stall and is gated by the global go strobe.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; low 2 bits must be 0
//  PC_STEP   4              byte increment per accepted fetch
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  go           in   1   run enable; 0 parks the fetcher
//  stall        in   1   IF back-pressure (IF_stage do_stall)
//  branch       in   1   redirect request from execute
//  branch_addr  in   32  redirect target
//  rom_ready    in   1   ROM accepts/returns the current request this cycle
//  pc_if        out  32  current fetch PC (registered)
//  rom_req      out  1   ROM read request (registered)
//  inst_valid   out  1   ROM data for pc_if is valid this cycle (combinational)
//  misalign     out  1   1-cycle pulse: last redirect target had addr[1:0]!=0
// BEHAVIOUR
//  Reset (async, reset==0): pc_if=RESET_PC, rom_req=0, misalign=0, state=IDLE; inst_valid=0 while in reset.
//  FSM states: IDLE, REQ, HOLD. rom_req = (state==REQ).
//  fire = rom_req & rom_ready.
//  inst_valid = fire & ~branch & ~stall.
//  Transition priority, highest first, evaluated every edge:
//   1. go==0                     -> IDLE; pc_if held (resume from same PC)
//   2. branch==1                 -> REQ; pc_if<=branch_addr&~3; wins over stall and fire; no inst_valid that cycle
//   3. stall==1 (REQ or HOLD)    -> HOLD; pc_if held
//   4. IDLE or HOLD              -> REQ; pc_if held
//   5. REQ & fire                -> REQ; pc_if<=pc_if+PC_STEP
//   6. REQ & ~rom_ready          -> REQ; pc_if and rom_req held stable until accepted
//  Latency: go rising -> rom_req=1 on the next edge.
//  Latency: branch sampled -> new pc_if on rom_req at the next edge (one bubble cycle).
//  Width: 32-bit unsigned add, carry discarded; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
//  misalign: registered; 1 for exactly one cycle after a branch with branch_addr[1:0]!=0.
//   Target is still taken with low bits cleared.
//  Simultaneous stall and fire: fetch is not accepted; pc held; ROM must re-supply the data after stall clears.
//  Reset mid-request: rom_req drops immediately (async); pending ROM data is ignored.
// CONFIGURATION
//  PCGEN_FETCH_CNT_EN defined:
//   - Adds output fetch_count[31:0]; reset value 0.
//   - Increments by 1 on each inst_valid cycle; wraps at 2^32.
//   - Does not count across branch bubbles.
//  PCGEN_FETCH_CNT_EN undefined:
//   - Port and counter are absent.
//   - All other behaviour is identical.
// TESTING
//  T1 reset: assert reset=0 mid-run, go=1 -> pc_if=RESET_PC, rom_req=0, misalign=0 asynchronously.
//  T2 sequential: go=1, rom_ready=1 constant, from RESET_PC=0
//   -> pc_if 0,4,8,C on consecutive cycles; inst_valid=1 each cycle.
//  T3 ROM wait: rom_ready=0 for 3 cycles at pc_if=0x10
//   -> pc_if stays 0x10, rom_req=1, inst_valid=0; advances to 0x14 one edge after rom_ready=1.
//  T4 branch vs stall: stall=1 and branch=1 with branch_addr=0x0000_0102 in the same cycle
//   -> next pc_if=0x100, rom_req=1, misalign=1 for one cycle; inst_valid=0 in the branch cycle.
//  T5 stall/go: stall=1 for 2 cycles at 0x20
//   -> HOLD, rom_req=0, pc 0x20; go=0 then go=1 -> fetch resumes at 0x20.
//  T6 wrap/counter: start at 0xFFFF_FFF8 with rom_ready=1
//   -> pc_if 0xFFFF_FFFC then 0x0; with PCGEN_FETCH_CNT_EN, fetch_count increments 1 per valid.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// ============================================================================
// Module   : pc_fetch_gen
// Purpose  : Fetch program-counter generator and instruction-ROM request
//            sequencer feeding IF_stage. Optional macro PCGEN_FETCH_CNT_EN
//            adds a 32-bit count of delivered instructions (fetch_count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  input  logic        rom_ready,
  output logic [31:0] pc_if,
  output logic        rom_req,
  output logic        inst_valid,
`ifdef PCGEN_FETCH_CNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_rom_req;
  logic        r_misalign;
  logic        w_fire;

  assign w_fire     = r_rom_req & rom_ready;
  // A fetch that coincides with a redirect or back-pressure is discarded.
  assign inst_valid = w_fire & ~branch & ~stall;

  assign pc_if    = r_pc;
  assign rom_req  = r_rom_req;
  assign misalign = r_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_rom_req  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (!go) begin
        r_state   <= ST_IDLE;
        r_rom_req <= 1'b0;
      end else if (branch) begin
        r_state    <= ST_REQ;
        r_rom_req  <= 1'b1;
        r_pc       <= branch_addr & ~32'd3;
        r_misalign <= |branch_addr[1:0];
      end else if (stall && (r_state != ST_IDLE)) begin
        r_state   <= ST_HOLD;
        r_rom_req <= 1'b0;
      end else if (r_state != ST_REQ) begin
        r_state   <= ST_REQ;
        r_rom_req <= 1'b1;
      end else if (w_fire) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

`ifdef PCGEN_FETCH_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= 32'd0;
    end else if (inst_valid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
// ============================================================================
// Module   : tb_pc_fetch_gen
// Purpose  : Self-checking bench for pc_fetch_gen; delivered fetch addresses
//            are queued as stimulus is applied and matched on inst_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_gen;

  logic        clk;
  logic        reset;
  logic        go;
  logic        stall;
  logic        branch;
  logic [31:0] branch_addr;
  logic        rom_ready;
  logic [31:0] pc_if;
  logic        rom_req;
  logic        inst_valid;
  logic        misalign;
`ifdef PCGEN_FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [31:0] sb[$];

  pc_fetch_gen dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .stall       (stall),
    .branch      (branch),
    .branch_addr (branch_addr),
    .rom_ready   (rom_ready),
    .pc_if       (pc_if),
    .rom_req     (rom_req),
    .inst_valid  (inst_valid),
`ifdef PCGEN_FETCH_CNT_EN
    .fetch_count (fetch_count),
`endif
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    sb.push_back(addr);
    exp_cnt++;
  endtask

  // Inputs are set by the caller; outputs are sampled mid-cycle, then the edge.
  task automatic expect_cycle(input string tag, input logic [31:0] pc, input logic req,
                              input logic iv, input logic mis);
    @(negedge clk);
    chk_eq({tag, "_pc"},  pc_if, pc);
    chk_eq({tag, "_req"}, {31'd0, rom_req}, {31'd0, req});
    chk_eq({tag, "_iv"},  {31'd0, inst_valid}, {31'd0, iv});
    chk_eq({tag, "_mis"}, {31'd0, misalign}, {31'd0, mis});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && inst_valid) begin
      if (sb.size() == 0) chk_eq("sb_under", 32'd1, 32'd0);
      else                chk_eq("sb_pc", pc_if, sb.pop_front());
    end
  end

  initial begin
    reset = 1'b0; go = 1'b0; stall = 1'b0; branch = 1'b0;
    branch_addr = 32'd0; rom_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_pc",  pc_if, 32'h0);
    chk_eq("rst_req", {31'd0, rom_req}, 32'd0);
    chk_eq("rst_iv",  {31'd0, inst_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Sequential fetch from reset PC
    go = 1'b1; rom_ready = 1'b1;
    expect_cycle("t2_idle", 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4));
      expect_cycle("t2_seq", 32'(i * 4), 1'b1, 1'b1, 1'b0);
    end

    // ROM wait states
    rom_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle("t3_wait", 32'h10, 1'b1, 1'b0, 1'b0);
    rom_ready = 1'b1;
    push(32'h10);
    expect_cycle("t3_acc", 32'h10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(32'h14 + 32'(i * 4));
      expect_cycle("t3_seq", 32'h14 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
    end

    // Stall then go park/resume at 0x20
    stall = 1'b1;
    expect_cycle("t5_st0", 32'h20, 1'b1, 1'b0, 1'b0);
    expect_cycle("t5_hold", 32'h20, 1'b0, 1'b0, 1'b0);
    stall = 1'b0; go = 1'b0;
    expect_cycle("t5_go0", 32'h20, 1'b0, 1'b0, 1'b0);
    go = 1'b1;
    expect_cycle("t5_idle", 32'h20, 1'b0, 1'b0, 1'b0);
    push(32'h20);
    expect_cycle("t5_res", 32'h20, 1'b1, 1'b1, 1'b0);

    // Branch wins over stall; misaligned target
    stall = 1'b1; branch = 1'b1; branch_addr = 32'h0000_0102;
    expect_cycle("t4_br", 32'h24, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; branch = 1'b0;
    push(32'h100);
    expect_cycle("t4_tgt", 32'h100, 1'b1, 1'b1, 1'b1);
    push(32'h104);
    expect_cycle("t4_nxt", 32'h104, 1'b1, 1'b1, 1'b0);

    // Aligned branch during an accepted fetch
    branch = 1'b1; branch_addr = 32'h0000_0200;
    expect_cycle("br2", 32'h108, 1'b1, 1'b0, 1'b0);
    branch = 1'b0;
    push(32'h200);
    expect_cycle("br2_tgt", 32'h200, 1'b1, 1'b1, 1'b0);

    // Wrap at top of address space
    branch = 1'b1; branch_addr = 32'hFFFF_FFF8;
    expect_cycle("t6_br", 32'h204, 1'b1, 1'b0, 1'b0);
    branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'hFFFF_FFF8 + 32'(i * 4));
      expect_cycle("t6_wrap", 32'hFFFF_FFF8 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
    end
`ifdef PCGEN_FETCH_CNT_EN
    chk_eq("cnt", fetch_count, 32'(exp_cnt));
`endif

    // Async reset mid-request with misalign pending
    branch = 1'b1; branch_addr = 32'h0000_0033;
    expect_cycle("t1_br", 32'h4, 1'b1, 1'b0, 1'b0);
    branch = 1'b0;
    chk_eq("t1_pre_pc",  pc_if, 32'h30);
    chk_eq("t1_pre_mis", {31'd0, misalign}, 32'd1);
    reset = 1'b0;
    #1;
    chk_eq("t1_pc",  pc_if, 32'h0);
    chk_eq("t1_req", {31'd0, rom_req}, 32'd0);
    chk_eq("t1_mis", {31'd0, misalign}, 32'd0);
    chk_eq("t1_iv",  {31'd0, inst_valid}, 32'd0);
`ifdef PCGEN_FETCH_CNT_EN
    chk_eq("t1_cnt", fetch_count, 32'd0);
    exp_cnt = 0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_cycle("t1_idle", 32'h0, 1'b0, 1'b0, 1'b0);
    push(32'h0);
    expect_cycle("t1_run", 32'h0, 1'b1, 1'b1, 1'b0);
`ifdef PCGEN_FETCH_CNT_EN
    chk_eq("t1_cnt1", fetch_count, 32'(exp_cnt));
`endif

    chk_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
